// File: rtl/key_ctrl_pkg.sv
// rtl/key_ctrl_pkg.sv - shared state encoding, key roles and width helper for key_step_ctrl
package key_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_STEP = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  localparam int KEY_RST  = 0;
  localparam int KEY_STEP = 1;
  localparam int KEY_HLT  = 2;
  localparam int KEY_MODE = 3;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one push-button: synchroniser, stability counter, level and press pulse
module key_debounce
  import key_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter measures how long the synced level has disagreed with the accepted level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      level_d = sync2_q;
      press_d = sync2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= ~key_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/key_step_ctrl.sv
// rtl/key_step_ctrl.sv - debounced keys driving CPU reset, single-step/free-run clock enable and halt
module key_step_ctrl
  import key_ctrl_pkg::*;
#(
  parameter int NKEYS           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RST_HOLD        = 16,
  parameter int RUN_DIV         = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] key_n,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] key_press,
  output logic             cpu_rst,
  output logic             cpu_clk_en,
  output logic             cpu_hlt,
  output logic             run_mode
);

  localparam int HW = clog2(RST_HOLD);
  localparam int PW = clog2(RUN_DIV);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(RST_HOLD - 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(RUN_DIV - 1);

  for (genvar g = 0; g < NKEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i  (clk),
      .rst_i  (rst),
      .key_n_i(key_n[g]),
      .level_o(key_level[g]),
      .press_o(key_press[g])
    );
  end

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          hlt_q, hlt_d;
  logic          clk_en_q, clk_en_d;
  logic          cpu_rst_q, run_mode_q;
  logic          advance;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    presc_d = presc_q;
    hlt_d   = hlt_q;
    advance = 1'b0;
    if (key_level[KEY_RST]) begin
      state_d = S_RST;
      hold_d  = '0;
      hlt_d   = 1'b0;
    end else begin
      case (state_q)
        S_RST: begin
          hlt_d = 1'b0;
          if (hold_q == HOLD_MAX) begin
            state_d = S_STEP;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        S_STEP: begin
          if (key_press[KEY_HLT]) hlt_d = ~hlt_q;
          advance = key_press[KEY_STEP];
          if (key_press[KEY_MODE]) begin
            state_d = S_RUN;
            presc_d = '0;
          end
        end
        S_RUN: begin
          if (key_press[KEY_HLT]) hlt_d = ~hlt_q;
          if (key_press[KEY_MODE]) begin
            state_d = S_STEP;
            presc_d = '0;
          end else if (!hlt_q) begin
            // Halt freezes the prescaler so the run phase resumes where it stopped.
            if (presc_q == PRESC_MAX) begin
              presc_d = '0;
              advance = 1'b1;
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end
        end
        default: state_d = S_RST;
      endcase
    end
    clk_en_d = advance & ~hlt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RST;
      hold_q     <= '0;
      presc_q    <= '0;
      hlt_q      <= 1'b0;
      clk_en_q   <= 1'b0;
      cpu_rst_q  <= 1'b1;
      run_mode_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      presc_q    <= presc_d;
      hlt_q      <= hlt_d;
      clk_en_q   <= clk_en_d;
      cpu_rst_q  <= (state_d == S_RST);
      run_mode_q <= (state_d == S_RUN);
    end
  end

  assign cpu_rst    = cpu_rst_q;
  assign cpu_clk_en = clk_en_q;
  assign cpu_hlt    = hlt_q;
  assign run_mode   = run_mode_q;

endmodule

// File: tb/tb_key_step_ctrl.sv
// tb/tb_key_step_ctrl.sv - directed vectors plus randomized keys against a reference model
module tb_key_step_ctrl;

  localparam int NK = 4;
  localparam int DC = 4;
  localparam int RH = 3;
  localparam int RD = 3;
  localparam int M_RST = 0, M_STEP = 1, M_RUN = 2;

  logic          clk, rst;
  logic [NK-1:0] key_n, key_level, key_press;
  logic          cpu_rst, cpu_clk_en, cpu_hlt, run_mode;

  key_step_ctrl #(
    .NKEYS(NK), .DEBOUNCE_CYCLES(DC), .RST_HOLD(RH), .RUN_DIV(RD)
  ) dut (
    .clk(clk), .rst(rst), .key_n(key_n), .key_level(key_level), .key_press(key_press),
    .cpu_rst(cpu_rst), .cpu_clk_en(cpu_clk_en), .cpu_hlt(cpu_hlt), .run_mode(run_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests, fails;

  // Reference model: keys accepted once the last DC synced samples all disagree with the level.
  logic [NK-1:0] m_level, m_press;
  logic          m_rst, m_en, m_hlt, m_run;
  int            m_mode, m_rel, m_ticks;
  logic [31:0]   raw_hist [NK];
  logic [31:0]   sync_hist[NK];
  int            sync_len [NK];

  task automatic model_reset();
    m_level = '0; m_press = '0; m_rst = 1'b1; m_en = 1'b0; m_hlt = 1'b0; m_run = 1'b0;
    m_mode = M_RST; m_rel = 0; m_ticks = 0;
    for (int i = 0; i < NK; i++) begin
      raw_hist[i] = '0; sync_hist[i] = '0; sync_len[i] = 0;
    end
  endtask

  task automatic model_step();
    logic [NK-1:0] pr, n_level, n_press;
    logic [31:0]   mask;
    logic          s, n_hlt, n_en;
    int            n_mode;
    pr = m_press; n_level = m_level; n_press = '0;
    mask = (32'd1 << DC) - 32'd1;
    for (int i = 0; i < NK; i++) begin
      s = raw_hist[i][1];
      sync_hist[i] = {sync_hist[i][30:0], s};
      if (sync_len[i] < DC) sync_len[i]++;
      if (sync_len[i] == DC && (sync_hist[i] & mask) == (m_level[i] ? 32'd0 : mask)) begin
        n_level[i] = s; n_press[i] = s; sync_len[i] = 0;
      end
      raw_hist[i] = {raw_hist[i][30:0], ~key_n[i]};
    end
    n_mode = m_mode; n_hlt = m_hlt; n_en = 1'b0;
    if (m_level[0]) begin
      n_mode = M_RST; m_rel = 0; n_hlt = 1'b0;
    end else if (m_mode == M_RST) begin
      if (m_rel == RH - 1) begin n_mode = M_STEP; m_rel = 0; end
      else m_rel++;
    end else begin
      if (pr[2]) n_hlt = !m_hlt;
      if (m_mode == M_STEP) begin
        n_en = pr[1];
        if (pr[3]) begin n_mode = M_RUN; m_ticks = 0; end
      end else if (pr[3]) begin
        n_mode = M_STEP;
      end else if (!m_hlt) begin
        m_ticks++;
        n_en = (m_ticks % RD == 0);
      end
      n_en = n_en && !n_hlt;
    end
    m_level = n_level; m_press = n_press; m_mode = n_mode; m_hlt = n_hlt; m_en = n_en;
    m_rst = (n_mode == M_RST); m_run = (n_mode == M_RUN);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("key_level", 32'(key_level), 32'(m_level));
    chk("key_press", 32'(key_press), 32'(m_press));
    chk("cpu_rst", 32'(cpu_rst), 32'(m_rst));
    chk("cpu_clk_en", 32'(cpu_clk_en), 32'(m_en));
    chk("cpu_hlt", 32'(cpu_hlt), 32'(m_hlt));
    chk("run_mode", 32'(run_mode), 32'(m_run));
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  typedef struct {
    logic [3:0] kn;
    int         n;
    logic [3:0] lvl;
    logic       rst_e, run_e, hlt_e;
    int         pulses;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic [3:0] kn, input int n, input logic [3:0] lvl,
                     input logic rst_e, input logic run_e, input logic hlt_e, input int pulses);
    vec_t v;
    v.kn = kn; v.n = n; v.lvl = lvl; v.rst_e = rst_e; v.run_e = run_e; v.hlt_e = hlt_e;
    v.pulses = pulses;
    vq.push_back(v);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    tests = 0; fails = 0;
    rst = 1'b1; key_n = '1;
    repeat (2) cycle();
    chk("reset_key_level", 32'(key_level), 0);
    chk("reset_key_press", 32'(key_press), 0);
    chk("reset_cpu_rst", 32'(cpu_rst), 1);
    chk("reset_cpu_clk_en", 32'(cpu_clk_en), 0);
    chk("reset_cpu_hlt", 32'(cpu_hlt), 0);
    chk("reset_run_mode", 32'(run_mode), 0);
    rst = 1'b0;

    // key_n, cycles, level, cpu_rst, run_mode, cpu_hlt, clk_en pulses
    add(4'hF, 2, 4'h0, 1, 0, 0, 0);
    add(4'hF, 1, 4'h0, 0, 0, 0, 0);
    add(4'hD, 3, 4'h0, 0, 0, 0, 0);
    add(4'hF, 1, 4'h0, 0, 0, 0, 0);
    add(4'hD, 2, 4'h0, 0, 0, 0, 0);
    add(4'hF, 4, 4'h0, 0, 0, 0, 0);
    add(4'hD, 5, 4'h0, 0, 0, 0, 0);
    add(4'hD, 1, 4'h2, 0, 0, 0, 0);
    add(4'hD, 4, 4'h2, 0, 0, 0, 1);
    add(4'hF, 8, 4'h0, 0, 0, 0, 0);
    add(4'h7, 6, 4'h8, 0, 0, 0, 0);
    add(4'h7, 1, 4'h8, 0, 1, 0, 0);
    add(4'hF, 9, 4'h0, 0, 1, 0, 3);
    add(4'hB, 6, 4'h4, 0, 1, 0, 2);
    add(4'hF, 1, 4'h4, 0, 1, 1, 0);
    add(4'hF, 8, 4'h0, 0, 1, 1, 0);
    add(4'hB, 6, 4'h4, 0, 1, 1, 0);
    add(4'hF, 1, 4'h4, 0, 1, 0, 0);
    add(4'hF, 2, 4'h4, 0, 1, 0, 1);
    add(4'hE, 6, 4'h1, 0, 1, 0, 2);
    add(4'hE, 1, 4'h1, 1, 0, 0, 0);
    add(4'hE, 3, 4'h1, 1, 0, 0, 0);
    add(4'hF, 6, 4'h0, 1, 0, 0, 0);
    add(4'hF, 2, 4'h0, 1, 0, 0, 0);
    add(4'hF, 1, 4'h0, 0, 0, 0, 0);
    add(4'h5, 6, 4'hA, 0, 0, 0, 0);
    add(4'h5, 1, 4'hA, 0, 1, 0, 1);
    add(4'hF, 9, 4'h0, 0, 1, 0, 3);
    add(4'h7, 6, 4'h8, 0, 1, 0, 2);
    add(4'hF, 1, 4'h8, 0, 0, 0, 0);

    foreach (vq[v]) begin
      key_n = vq[v].kn;
      pulses = 0;
      repeat (vq[v].n) begin
        cycle();
        if (cpu_clk_en === 1'b1) pulses++;
      end
      chk($sformatf("vec%0d_level", v), 32'(key_level), 32'(vq[v].lvl));
      chk($sformatf("vec%0d_cpu_rst", v), 32'(cpu_rst), 32'(vq[v].rst_e));
      chk($sformatf("vec%0d_run_mode", v), 32'(run_mode), 32'(vq[v].run_e));
      chk($sformatf("vec%0d_cpu_hlt", v), 32'(cpu_hlt), 32'(vq[v].hlt_e));
      chk($sformatf("vec%0d_pulses", v), 32'(pulses), 32'(vq[v].pulses));
    end

    // Async reset with key1 mid-debounce, then key1 held through reset.
    key_n = 4'hF;
    repeat (8) cycle();
    key_n = 4'hD;
    repeat (4) cycle();
    rst = 1'b1;
    #1;
    chk("async_key_level", 32'(key_level), 0);
    chk("async_key_press", 32'(key_press), 0);
    chk("async_cpu_rst", 32'(cpu_rst), 1);
    chk("async_cpu_clk_en", 32'(cpu_clk_en), 0);
    chk("async_cpu_hlt", 32'(cpu_hlt), 0);
    chk("async_run_mode", 32'(run_mode), 0);
    compare_all();
    cycle();
    rst = 1'b0;
    repeat (5) cycle();
    chk("held_level_early", 32'(key_level), 0);
    cycle();
    chk("held_level", 32'(key_level), 32'h2);
    chk("held_press", 32'(key_press), 32'h2);

    for (int s = 0; s < 300; s++) begin
      logic [3:0] kn;
      kn = 4'($urandom);
      if ($urandom_range(0, 5) != 0) kn[0] = 1'b1;
      key_n = kn;
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        #1;
        compare_all();
        cycle();
        rst = 1'b0;
      end
      repeat ($urandom_range(1, 12)) cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
